// File: rtl/av2_pkg.sv
`default_nettype none
// ============================================================================
// Module   : av2_pkg
// Purpose  : Shared constants, FSM encodings and types for the AV2
//            reconstruction frame store.
// Revision : 1.0 - initial release
// ============================================================================
package av2_pkg;

  // Pixels carried by one reconstruction write beat
  localparam int PIXELS_PER_WORD = 16;

  // Pixel value returned before any reference frame exists
  localparam int DEFAULT_PIXEL = 128;

  // Write FSM encodings
  localparam int         STATE_W = 2;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_FULL = 2'd2;

  typedef logic [8*PIXELS_PER_WORD-1:0] pixel_word_t;

  // Read pipeline stage: everything needed to form the data one cycle later
  typedef struct packed {
    logic valid;  // a read was issued last cycle
    logic oor;    // that read was out of range
    logic avail;  // a reference frame existed at issue time
    logic sel;    // reference bank index at issue time
  } rd_stage_t;

  function automatic logic [31:0] min_u32(input logic [31:0] a, input logic [31:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/av2_recon_frame_store_if.sv
`default_nettype none
// ============================================================================
// Module   : av2_recon_frame_store_if
// Purpose  : Recon write bus and reference read bus of the frame store.
//            master = decoder side, slave = frame store.
// Revision : 1.0 - initial release
// ============================================================================
interface av2_recon_frame_store_if;
  import av2_pkg::*;

  pixel_word_t recon_data;
  logic [31:0] recon_addr;
  logic        recon_wr_en;
  logic        ref_read_en;
  logic [31:0] ref_read_addr;
  logic [9:0]  ref_pixel_data;
  logic        ref_pixel_valid;

  modport master (
    output recon_data, recon_addr, recon_wr_en, ref_read_en, ref_read_addr,
    input  ref_pixel_data, ref_pixel_valid
  );

  modport slave (
    input  recon_data, recon_addr, recon_wr_en, ref_read_en, ref_read_addr,
    output ref_pixel_data, ref_pixel_valid
  );

endinterface
`default_nettype wire

// File: rtl/av2_pixel_bank.sv
`default_nettype none
// ============================================================================
// Module   : av2_pixel_bank
// Purpose  : One pixel bank: 16-pixel-wide write port, single-pixel
//            synchronous read port. Contents are not reset.
// Revision : 1.0 - initial release
// ============================================================================
module av2_pixel_bank
  import av2_pkg::*;
#(
  parameter  int DEPTH   = 4096,
  localparam int ADDR_W  = $clog2(DEPTH),
  localparam int WORDS   = DEPTH / PIXELS_PER_WORD,
  localparam int WADDR_W = $clog2(WORDS)
) (
  input  logic               clk,
  input  logic               wr_en,
  input  logic [WADDR_W-1:0] wr_addr,
  input  pixel_word_t        wr_data,
  input  logic               rd_en,
  input  logic [ADDR_W-1:0]  rd_addr,
  output logic [7:0]         rd_data
);

  pixel_word_t r_mem [WORDS];
  logic [7:0]  r_rd_data;

  // Store a whole 16-pixel word
  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  // Registered single-pixel read: word by upper bits, byte lane by lower bits
  always_ff @(posedge clk) begin
    if (rd_en) begin
      r_rd_data <= r_mem[rd_addr[ADDR_W-1:4]][{rd_addr[3:0], 3'b000} +: 8];
    end
  end

  assign rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/av2_recon_frame_store.sv
`default_nettype none
// ============================================================================
// Module   : av2_recon_frame_store
// Purpose  : Double-buffered reconstructed-frame store. One bank takes
//            16-pixel recon writes while the other serves single-pixel
//            reference reads; tile_done swaps the roles.
// Revision : 1.0 - initial release
// ============================================================================
module av2_recon_frame_store #(
  parameter int MAX_WIDTH     = 64,
  parameter int MAX_HEIGHT    = 64,
  parameter int DEFAULT_PIXEL = av2_pkg::DEFAULT_PIXEL
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [15:0]                  frame_width,
  input  logic [15:0]                  frame_height,
  av2_recon_frame_store_if.slave       bus,
  input  logic                         tile_done,
  output logic                         frame_complete,
  output logic                         ref_available,
  output logic                         addr_error
);
  import av2_pkg::PIXELS_PER_WORD;
  import av2_pkg::ST_IDLE;
  import av2_pkg::ST_FILL;
  import av2_pkg::ST_FULL;
  import av2_pkg::rd_stage_t;
  import av2_pkg::min_u32;

  localparam int          DEPTH          = MAX_WIDTH * MAX_HEIGHT;
  localparam int          ADDR_W         = $clog2(DEPTH);
  localparam int          LANE_W         = $clog2(PIXELS_PER_WORD);
  localparam logic [31:0] C_DEPTH        = 32'(DEPTH);
  localparam logic [9:0]  C_DEFAULT_DATA = 10'(DEFAULT_PIXEL);

  logic [31:0] w_frame_size;
  logic [31:0] w_limit;
  logic [31:0] w_wr_base;
  logic        w_wr_ok;
  logic        w_wr_oor;
  logic        w_rd_oor;
  logic [15:0] w_count_next;
  logic [1:0]  w_state_next;
  logic [1:0]  r_state;
  logic [15:0] r_wr_count;
  logic        r_bank_ptr;     // index of the current write bank
  rd_stage_t   r_rd;
  logic [1:0][7:0] w_bank_rd_data;
  logic        w_unused_lsb;

  // Addresses are also capped at the physical bank size so an oversized
  // frame geometry can never alias into the start of the bank.
  assign w_frame_size = 32'(frame_width) * 32'(frame_height);
  assign w_limit      = min_u32(w_frame_size, C_DEPTH);
  assign w_wr_base    = {bus.recon_addr[31:LANE_W], {LANE_W{1'b0}}};
  assign w_unused_lsb = ^bus.recon_addr[LANE_W-1:0];

  assign w_wr_ok  = bus.recon_wr_en && (({1'b0, w_wr_base} + 33'd15) < {1'b0, w_limit});
  assign w_wr_oor = bus.recon_wr_en && !w_wr_ok;
  assign w_rd_oor = bus.ref_read_addr >= w_limit;

  // Two banks; the write bank never serves reads, so no read/write collision
  for (genvar i = 0; i < 2; i++) begin : g_bank
    av2_pixel_bank #(
      .DEPTH (DEPTH)
    ) u_bank (
      .clk     (clk),
      .wr_en   (w_wr_ok && (r_bank_ptr == 1'(i))),
      .wr_addr (w_wr_base[ADDR_W-1:LANE_W]),
      .wr_data (bus.recon_data),
      .rd_en   (bus.ref_read_en && !w_rd_oor && (r_bank_ptr != 1'(i))),
      .rd_addr (bus.ref_read_addr[ADDR_W-1:0]),
      .rd_data (w_bank_rd_data[i])
    );
  end

  // Saturating count of accepted write beats
  always_comb begin
    w_count_next = r_wr_count;
    if (w_wr_ok && (r_wr_count != 16'hFFFF)) begin
      w_count_next = r_wr_count + 16'd1;
    end
  end

  // Write counter, bank pointer and sticky status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_count    <= 16'd0;
      r_bank_ptr    <= 1'b0;
      ref_available <= 1'b0;
      addr_error    <= 1'b0;
    end else begin
      // A write in the tile_done cycle has already landed in the old bank
      r_wr_count <= tile_done ? 16'd0 : w_count_next;
      if (tile_done) begin
        r_bank_ptr    <= ~r_bank_ptr;
        ref_available <= 1'b1;
      end
      if (w_wr_oor || (bus.ref_read_en && w_rd_oor)) begin
        addr_error <= 1'b1;
      end
    end
  end

  // Write FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Write FSM next state; fullness judged on the post-write count
  always_comb begin
    w_state_next = r_state;
    if (tile_done) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (w_wr_ok) w_state_next = ST_FILL;
        ST_FILL: if ({12'd0, w_count_next, 4'd0} >= w_frame_size) w_state_next = ST_FULL;
        ST_FULL: w_state_next = ST_FULL;
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  // Write FSM outputs
  always_comb begin
    frame_complete = (r_state == ST_FULL);
  end

  // Capture issue-time context so a same-cycle swap cannot redirect the read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd <= '0;
    end else begin
      r_rd.valid <= bus.ref_read_en;
      r_rd.oor   <= w_rd_oor;
      r_rd.avail <= ref_available;
      r_rd.sel   <= ~r_bank_ptr;
    end
  end

  // Read data: out of range wins, then default before any frame, then bank
  always_comb begin
    bus.ref_pixel_data = 10'd0;
    if (r_rd.valid && !r_rd.oor) begin
      if (!r_rd.avail) begin
        bus.ref_pixel_data = C_DEFAULT_DATA;
      end else begin
        bus.ref_pixel_data = {2'b00, w_bank_rd_data[r_rd.sel]};
      end
    end
  end

  assign bus.ref_pixel_valid = r_rd.valid;

endmodule
`default_nettype wire
